// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
//   Instr     : instruction register bits [31:12]
//   ALUFlags  : {N,Z,C,V} from the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite : write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc : mux selects
//   ALUControl: ALU operation, State: current FSM state (debug)
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing fetch/decode/
// execute, ALU decoder, condition check and NZCV flag registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : controller side of multicycle_controller_if (instruction and
//           ALU flags in; enables, mux selects, ALUControl, State out)
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    // Instruction fields (port bit 0 is instruction bit 12)
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    assign cond  = bus.Instr[19:16];
    assign op    = bus.Instr[15:14];
    assign funct = bus.Instr[13:8];
    assign cmd   = funct[4:1];

    // Register fields are the datapath's business
    logic unused_regfields;
    assign unused_regfields = ^bus.Instr[7:0];

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q;          // {N,Z,C,V}
    logic       condex_q;
    logic       condex;

    // Moore control bits
    logic next_pc, branch, regw, memw, irw, aluop;
    logic [1:0] flagw;

    // Condition check against the registered flags
    logic fn, fz, fc, fv;
    assign {fn, fz, fc, fv} = flags_q;
    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = fz;
            4'b0001: condex = ~fz;
            4'b0010: condex = fc;
            4'b0011: condex = ~fc;
            4'b0100: condex = fn;
            4'b0101: condex = ~fn;
            4'b0110: condex = fv;
            4'b0111: condex = ~fv;
            4'b1000: condex = fc & ~fz;
            4'b1001: condex = ~fc | fz;
            4'b1010: condex = (fn == fv);
            4'b1011: condex = (fn != fv);
            4'b1100: condex = ~fz & (fn == fv);
            4'b1101: condex = fz | (fn != fv);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Next state
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: case (op)
                          2'b01:   state_d = S_MEMADR;
                          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                          2'b10:   state_d = S_BRANCH;
                          default: state_d = S_FETCH;
                      endcase
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;   // terminal and illegal states
        endcase
    end

    // Moore outputs
    always_comb begin
        next_pc = 1'b0; branch = 1'b0; regw = 1'b0; memw = 1'b0; irw = 1'b0;
        aluop = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        case (state_q)
            S_FETCH:  begin
                irw = 1'b1; next_pc = 1'b1;
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
            end
            S_MEMADR: bus.ALUSrcB = 2'b01;
            S_MEMRD:  bus.AdrSrc = 1'b1;
            S_MEMWB:  begin bus.ResultSrc = 2'b01; regw = 1'b1; end
            S_MEMWR:  begin bus.AdrSrc = 1'b1; memw = 1'b1; end
            S_EXECR:  aluop = 1'b1;
            S_EXECI:  begin bus.ALUSrcB = 2'b01; aluop = 1'b1; end
            S_ALUWB:  regw = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10; branch = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; flag writes only happen when ALUOp is set (EXEC states)
    always_comb begin
        bus.ALUControl = 2'b00;
        flagw          = 2'b00;
        if (aluop) begin
            case (cmd)
                4'b0010: bus.ALUControl = 2'b01;
                4'b0000: bus.ALUControl = 2'b10;
                4'b1100: bus.ALUControl = 2'b11;
                default: bus.ALUControl = 2'b00;
            endcase
            flagw[1] = funct[0];
            flagw[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010));
        end
    end

    // Write enables are also gated by reset so nothing escapes while it is low
    assign bus.PCWrite  = reset & (next_pc | (branch & condex_q));
    assign bus.MemWrite = reset & memw & condex_q;
    assign bus.RegWrite = reset & regw & condex_q;
    assign bus.IRWrite  = reset & irw;

    assign bus.ImmSrc = op;
    assign bus.RegSrc = {op == 2'b01, op == 2'b10};
    assign bus.State  = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) condex_q <= condex;
            if (flagw[1] & condex_q) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (flagw[0] & condex_q) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end
endmodule
